// File: rtl/mem_pkg.sv
// Shared memory-access encodings: access size codes, access FSM states and
// size/byte-mask helpers, also used by the execute stage for mem_rd/wr_size.
package mem_pkg;

  localparam logic [1:0] SZ_B    = 2'b00;
  localparam logic [1:0] SZ_W    = 2'b01;
  localparam logic [1:0] SZ_D    = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2
  } state_e;

  // The reserved size is treated as a full word; the error flag is raised elsewhere.
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    logic [2:0] b;
    case (size)
      SZ_B:    b = 3'd1;
      SZ_W:    b = 3'd2;
      default: b = 3'd4;
    endcase
    return b;
  endfunction

  function automatic logic [3:0] byte_mask(input logic [2:0] bytes);
    logic [3:0] m;
    case (bytes)
      3'd1:    m = 4'b0001;
      3'd2:    m = 4'b0011;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mem_align.sv
// Byte-lane alignment for one cache beat: byte enables, lane-aligned write
// data and the shifted piece of read data that this beat contributes.
module mem_align
  import mem_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [1:0]        off_i,
  input  logic [2:0]        bytes_i,
  input  logic              beat_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [DATA_W-1:0] rdata_i,
  output logic [3:0]        be_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic [DATA_W-1:0] rdata_o
);

  logic [5:0]          sh;
  logic [7:0]          be_wide;
  logic [2*DATA_W-1:0] w_wide;
  logic [2*DATA_W-1:0] r_wide;

  // Shifting into a double-width vector yields both beats at once: the low
  // half is the first word, the high half is what spills into the next word.
  always_comb begin
    sh      = {off_i, 3'b000};
    be_wide = {4'b0000, byte_mask(bytes_i)} << off_i;
    w_wide  = {{DATA_W{1'b0}}, wdata_i} << sh;
    r_wide  = {rdata_i, {DATA_W{1'b0}}} >> sh;
    be_o    = beat_i ? be_wide[7:4] : be_wide[3:0];
    wdata_o = beat_i ? w_wide[2*DATA_W-1:DATA_W] : w_wide[DATA_W-1:0];
    rdata_o = beat_i ? r_wide[DATA_W-1:0] : r_wide[2*DATA_W-1:DATA_W];
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory-stage access controller: takes one load/store/stack request and
// drives it onto the D-cache as one or two word-aligned beats.
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_we,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_wdata,
  input  logic [1:0]        in_size,
  output logic              dc_req,
  output logic              dc_we,
  output logic [ADDR_W-1:0] dc_addr,
  output logic [3:0]        dc_be,
  output logic [DATA_W-1:0] dc_wdata,
  input  logic              dc_ack,
  input  logic [DATA_W-1:0] dc_rdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              busy
);

  state_e            state_q, state_d;
  logic              we_q, err_q, cross_q;
  logic [ADDR_W-1:0] addr_q, word_addr;
  logic [DATA_W-1:0] wdata_q, acc_q, acc_d, merged;
  logic [2:0]        bytes_q, in_bytes;
  logic              resp_valid_q, resp_valid_d, resp_err_q, resp_err_d;
  logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
  logic              accept, beat, done;
  logic [3:0]        al_be, rmask;
  logic [DATA_W-1:0] al_wdata, al_rpart, rmask_w;

  assign in_bytes   = size_bytes(in_size);
  assign in_ready   = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign accept     = in_valid && in_ready;
  assign beat       = (state_q == BEAT1);
  assign word_addr  = {addr_q[ADDR_W-1:2], 2'b00};
  assign rmask      = byte_mask(bytes_q);
  assign rmask_w    = {{8{rmask[3]}}, {8{rmask[2]}}, {8{rmask[1]}}, {8{rmask[0]}}};
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

  mem_align #(.DATA_W(DATA_W)) u_align (
    .off_i   (addr_q[1:0]),
    .bytes_i (bytes_q),
    .beat_i  (beat),
    .wdata_i (wdata_q),
    .rdata_i (dc_rdata),
    .be_o    (al_be),
    .wdata_o (al_wdata),
    .rdata_o (al_rpart)
  );

  always_ff @(posedge clk) begin
    if (accept) begin
      we_q    <= in_we;
      addr_q  <= in_addr;
      wdata_q <= in_wdata;
      bytes_q <= in_bytes;
      err_q   <= (in_size == SZ_RSVD);
      cross_q <= ({2'b00, in_addr[1:0]} + {1'b0, in_bytes}) > 4'd4;
    end
    acc_q <= acc_d;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    merged   = acc_q;
    done     = 1'b0;
    dc_req   = 1'b0;
    dc_we    = 1'b0;
    dc_addr  = '0;
    dc_be    = '0;
    dc_wdata = '0;
    case (state_q)
      IDLE: if (in_valid) state_d = BEAT0;
      BEAT0, BEAT1: begin
        dc_req   = 1'b1;
        dc_we    = we_q;
        dc_addr  = beat ? word_addr + ADDR_W'(4) : word_addr;
        dc_be    = al_be;
        dc_wdata = al_wdata;
        if (dc_ack) begin
          merged = beat ? (acc_q | al_rpart) : al_rpart;
          acc_d  = merged;
          if (!beat && cross_q) begin
            state_d = BEAT1;
          end else begin
            state_d = IDLE;
            done    = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Response registered so the FSM is already idle while resp_valid is high.
    resp_valid_d = done;
    resp_err_d   = done ? err_q : resp_err_q;
    resp_rdata_d = resp_rdata_q;
    if (done) resp_rdata_d = we_q ? '0 : (merged & rmask_w);
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: byte-level reference memory model,
// word-level cache responder, and separate beat/response monitors.
module tb_mem_access_ctrl;

  logic        clk, rst, in_valid, in_ready, in_we;
  logic [31:0] in_addr, in_wdata;
  logic [1:0]  in_size;
  logic        dc_req, dc_we, dc_ack;
  logic [31:0] dc_addr, dc_wdata, dc_rdata;
  logic [3:0]  dc_be;
  logic        resp_valid, resp_err, busy;
  logic [31:0] resp_rdata;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wdata;
  } beat_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
    int          lat;
  } resp_t;

  beat_t       exp_beats[$];
  resp_t       exp_resps[$];
  logic [31:0] cmem [logic [31:0]];
  logic [7:0]  rmem [logic [31:0]];
  int          wait_cfg, cyc, npass, ntot, last_acc;
  bit          stray_req;

  mem_access_ctrl dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_we(in_we),
    .in_addr(in_addr), .in_wdata(in_wdata), .in_size(in_size),
    .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_be(dc_be), .dc_wdata(dc_wdata),
    .dc_ack(dc_ack), .dc_rdata(dc_rdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  function automatic logic [31:0] init_word(input logic [31:0] w);
    return (w * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  function automatic logic [31:0] cread(input logic [31:0] w);
    return cmem.exists(w) ? cmem[w] : init_word(w);
  endfunction

  function automatic logic [7:0] rbyte(input logic [31:0] a);
    logic [31:0] w;
    logic [1:0]  l;
    if (rmem.exists(a)) return rmem[a];
    w = init_word({a[31:2], 2'b00});
    l = a[1:0];
    return w[8*l +: 8];
  endfunction

  function automatic logic [31:0] lanes(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h, want %h", nm, act, exp);
  endtask

  task automatic preload(input logic [31:0] w, input logic [31:0] d);
    cmem[w] = d;
    for (int l = 0; l < 4; l++) rmem[w + 32'(l)] = d[8*l +: 8];
  endtask

  // Reference: walk the accessed bytes one at a time, group them by word.
  task automatic model(input logic we, input logic [31:0] a, input logic [31:0] wd,
                       input logic [1:0] sz);
    int          nbytes, nb, bi;
    logic [31:0] w0, ba, rd;
    logic [3:0]  be_a [2];
    logic [31:0] wl_a [2];
    beat_t       b;
    resp_t       r;
    nbytes = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    w0 = {a[31:2], 2'b00};
    rd = '0;
    nb = 1;
    be_a[0] = '0; be_a[1] = '0; wl_a[0] = '0; wl_a[1] = '0;
    for (int i = 0; i < nbytes; i++) begin
      ba = a + 32'(i);
      bi = ({ba[31:2], 2'b00} == w0) ? 0 : 1;
      if (bi == 1) nb = 2;
      be_a[bi][ba[1:0]] = 1'b1;
      wl_a[bi][8*ba[1:0] +: 8] = wd[8*i +: 8];
      if (we) rmem[ba] = wd[8*i +: 8];
      else rd[8*i +: 8] = rbyte(ba);
    end
    for (int k = 0; k < nb; k++) begin
      b.addr  = w0 + 32'(4*k);
      b.be    = be_a[k];
      b.we    = we;
      b.wdata = wl_a[k];
      exp_beats.push_back(b);
    end
    r.rdata = we ? 32'h0 : rd;
    r.err   = (sz == 2'b11);
    r.acc   = cyc;
    r.lat   = 1 + nb * (wait_cfg + 1);
    exp_resps.push_back(r);
  endtask

  // Called just after a negedge; returns at the negedge after the accept edge.
  task automatic issue(input logic we, input logic [31:0] a, input logic [31:0] wd,
                       input logic [1:0] sz);
    int n = 0;
    while (in_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (in_ready !== 1'b1) begin
      ntot++;
      $display("FAIL accept_timeout: in_ready %b, want 1", in_ready);
      return;
    end
    model(we, a, wd, sz);
    last_acc = cyc;
    in_valid = 1'b1; in_we = we; in_addr = a; in_wdata = wd; in_size = sz;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_resp();
    int n = 0;
    while (resp_valid !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (resp_valid !== 1'b1) begin
      ntot++;
      $display("FAIL resp_timeout: resp_valid %b, want 1", resp_valid);
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_resps.size() != 0 || busy !== 1'b0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_resps.size() != 0 || busy !== 1'b0) begin
      ntot++;
      $display("FAIL drain_timeout: %0d responses outstanding, want 0", exp_resps.size());
      exp_resps.delete();
      exp_beats.delete();
    end
  endtask

  // Cache responder and beat monitor.
  initial begin
    beat_t       b;
    logic [31:0] w;
    int          wcnt;
    dc_ack = 1'b0;
    dc_rdata = '0;
    wcnt = 0;
    forever begin
      @(negedge clk);
      dc_ack = 1'b0;
      if (stray_req) begin
        dc_ack = 1'b1;
        dc_rdata = $urandom;
        stray_req = 1'b0;
      end else if (dc_req === 1'b1) begin
        if (wcnt < wait_cfg) wcnt++;
        else begin
          wcnt = 0;
          dc_ack = 1'b1;
          dc_rdata = cread(dc_addr);
          if (exp_beats.size() == 0) begin
            ntot++;
            $display("FAIL beat_unexpected: dc_addr %h, want no beat", dc_addr);
          end else begin
            b = exp_beats.pop_front();
            chk("dc_addr", dc_addr, b.addr);
            chk("dc_be", {28'h0, dc_be}, {28'h0, b.be});
            chk("dc_we", {31'h0, dc_we}, {31'h0, b.we});
            chk("dc_wdata", dc_wdata & lanes(b.be), b.wdata);
          end
          if (dc_we === 1'b1) begin
            w = cread(dc_addr);
            cmem[dc_addr] = (w & ~lanes(dc_be)) | (dc_wdata & lanes(dc_be));
          end
        end
      end else wcnt = 0;
    end
  end

  // Response monitor.
  initial begin
    resp_t r;
    forever begin
      @(negedge clk);
      if (resp_valid === 1'b1) begin
        if (exp_resps.size() == 0) begin
          ntot++;
          $display("FAIL resp_unexpected: rdata %h, want no response", resp_rdata);
        end else begin
          r = exp_resps.pop_front();
          chk("resp_rdata", resp_rdata, r.rdata);
          chk("resp_err", {31'h0, resp_err}, {31'h0, r.err});
          chk("resp_latency", 32'(cyc - r.acc), 32'(r.lat));
        end
      end
    end
  end

  initial begin
    int          rc, n, reqlow, seen;
    logic [31:0] b1, a;
    npass = 0; ntot = 0; wait_cfg = 0; stray_req = 1'b0; last_acc = 0;
    rst = 1'b0; in_valid = 1'b0; in_we = 1'b0; in_addr = '0; in_wdata = '0; in_size = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_dc_req", {31'h0, dc_req}, 32'h0);
    chk("rst_dc_we", {31'h0, dc_we}, 32'h0);
    chk("rst_dc_addr", dc_addr, 32'h0);
    chk("rst_dc_be", {28'h0, dc_be}, 32'h0);
    chk("rst_dc_wdata", dc_wdata, 32'h0);
    chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_resp_err", {31'h0, resp_err}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_in_ready", {31'h0, in_ready}, 32'h1);
    rst = 1'b1;
    @(negedge clk);

    // 4B push, single beat, zero-wait
    wait_cfg = 0;
    issue(1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 2'b10);
    drain();

    // 4B pop crossing a word boundary
    preload(32'h0000_2000, 32'h1122_3344);
    preload(32'h0000_2004, 32'h5566_7788);
    issue(1'b0, 32'h0000_2002, 32'h0, 2'b10);
    wait_resp();
    chk("t2_rdata", resp_rdata, 32'h7788_1122);
    drain();

    // 1B write in the top lane
    issue(1'b1, 32'h0000_0103, 32'h0000_00AB, 2'b00);
    drain();

    // wrapping crossing read with two wait cycles per beat
    wait_cfg = 2;
    issue(1'b0, 32'hFFFF_FFFE, 32'h0, 2'b10);
    reqlow = 0; b1 = 32'hFFFF_FFFF; n = 0;
    while (resp_valid !== 1'b1 && n < 40) begin
      if (dc_req !== 1'b1) reqlow++;
      if (dc_req === 1'b1 && dc_be == 4'b0011) b1 = dc_addr;
      @(negedge clk);
      n++;
    end
    chk("t4_beat1_addr", b1, 32'h0);
    chk("t4_req_gaps", 32'(reqlow), 32'h0);
    drain();

    // reset during BEAT1, stray ack afterwards
    wait_cfg = 3;
    issue(1'b0, 32'h0000_0302, 32'h0, 2'b10);
    n = 0;
    while (!(dc_req === 1'b1 && dc_addr == 32'h0000_0304) && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("t5_reached_beat1", dc_addr, 32'h0000_0304);
    rst = 1'b0;
    exp_beats.delete();
    exp_resps.delete();
    @(posedge clk);
    #1;
    stray_req = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    chk("t5_dc_req", {31'h0, dc_req}, 32'h0);
    chk("t5_busy", {31'h0, busy}, 32'h0);
    chk("t5_resp_rdata", resp_rdata, 32'h0);
    chk("t5_resp_err", {31'h0, resp_err}, 32'h0);
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (resp_valid === 1'b1 || busy === 1'b1) seen++;
      @(negedge clk);
    end
    chk("t5_no_resp", 32'(seen), 32'h0);
    wait_cfg = 0;
    issue(1'b0, 32'h0000_0304, 32'h0, 2'b01);
    drain();

    // reserved size, back-to-back request in the response cycle
    issue(1'b0, 32'h0000_0010, 32'h0, 2'b11);
    wait_resp();
    rc = cyc;
    chk("t6_ready_in_resp", {31'h0, in_ready}, 32'h1);
    issue(1'b0, 32'h0000_0021, 32'h0, 2'b01);
    chk("t6_same_cycle", 32'(last_acc), 32'(rc));
    drain();

    // randomized mix over a small region and the top of the address space
    for (int t = 0; t < 60; t++) begin
      wait_cfg = $urandom_range(0, 2);
      if ($urandom_range(0, 3) == 0) a = 32'hFFFF_FFF8 + 32'($urandom_range(0, 7));
      else a = 32'h0000_0400 + 32'($urandom_range(0, 31));
      issue(1'($urandom_range(0, 1)), a, $urandom, 2'($urandom_range(0, 3)));
      drain();
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
